// File: rtl/axi_ni_request_packetizer.sv
// AXI slave to NoC packetizer: a read becomes one header+tail flit, a write becomes a header plus AWLEN+1 payload flits.
// Define NI_WLAST_CHECK_EN to enable the sticky WLAST-vs-beat-count error flag.
module axi_ni_request_packetizer #(
  parameter int OUTSTANDING_MAX = 8,
  parameter int ID_WD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ID_WD-1:0] AWID,
  input  logic [31:0]      AWADDR,
  input  logic [3:0]       AWLEN,
  input  logic [2:0]       AWSIZE,
  input  logic [1:0]       AWBURST,
  input  logic [1:0]       AWLOCK,
  input  logic [3:0]       AWCACHE,
  input  logic [2:0]       AWPROT,
  input  logic             AWVALID,
  output logic             AWREADY,
  input  logic [63:0]      WDATA,
  input  logic [7:0]       WSTRB,
  input  logic             WLAST,
  input  logic             WVALID,
  output logic             WREADY,
  input  logic [ID_WD-1:0] ARID,
  input  logic [31:0]      ARADDR,
  input  logic [3:0]       ARLEN,
  input  logic [2:0]       ARSIZE,
  input  logic [1:0]       ARBURST,
  input  logic [1:0]       ARLOCK,
  input  logic [3:0]       ARCACHE,
  input  logic [2:0]       ARPROT,
  input  logic             ARVALID,
  output logic             ARREADY,
  output logic [79:0]      flit,
  output logic             valid,
  input  logic             stall,
  input  logic [3:0]       SOURCE,
  output logic [3:0]       lut_address,
  input  logic [6:0]       lut_path,
  input  logic             resp_done,
  output logic             wlast_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_t;

  localparam logic [3:0] OMAX = 4'(OUTSTANDING_MAX);

  state_t      state_q, state_d;
  logic [3:0]  outst_q, outst_d;
  logic        prio_rd_q, prio_rd_d;
  logic        is_rd_q;
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic        lock_q;
  logic [3:0]  cache_q;
  logic [2:0]  prot_q;
  logic [3:0]  beat_cnt_q;
  logic        beats_done_q;
  logic [79:0] data_flit_q;
  logic        data_valid_q;

  logic        can_accept_s, accept_s, grant_rd_s, grant_wr_s;
  logic        w_beat_s, data_xfer_s, tail_xfer_s, dec_s;
  logic [79:0] header_s;
  logic        unused_s;

  assign can_accept_s = (state_q == IDLE) && (outst_q < OMAX);
  assign grant_rd_s   = ARVALID && (!AWVALID || prio_rd_q);
  assign grant_wr_s   = AWVALID && !grant_rd_s;
  assign accept_s     = can_accept_s && (ARVALID || AWVALID);
  assign ARREADY      = can_accept_s && grant_rd_s;
  assign AWREADY      = can_accept_s && grant_wr_s;

  // No beats are taken once the counter-determined final beat is buffered.
  assign WREADY      = (state_q == DATA) && !beats_done_q && (!data_valid_q || !stall);
  assign w_beat_s    = WREADY && WVALID;
  assign data_xfer_s = data_valid_q && !stall;
  assign tail_xfer_s = (state_q == DATA) && beats_done_q && data_xfer_s;
  assign dec_s       = resp_done && (outst_q != 4'd0);

  assign header_s = {(is_rd_q ? 2'b11 : 2'b01), lut_path, SOURCE, is_rd_q, id_q, addr_q,
                     len_q, size_q, burst_q, lock_q, cache_q, prot_q, 13'd0};
  assign flit        = (state_q == HDR) ? header_s : data_flit_q;
  assign valid       = (state_q == HDR) || data_valid_q;
  assign lut_address = addr_q[31:28];

  // State, outstanding count and arbitration priority registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      outst_q   <= 4'd0;
      prio_rd_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      outst_q   <= outst_d;
      prio_rd_q <= prio_rd_d;
    end
  end

  // Next-state, outstanding count and priority update.
  always_comb begin
    state_d   = state_q;
    outst_d   = outst_q;
    prio_rd_d = prio_rd_q;
    case (state_q)
      IDLE:    if (accept_s) state_d = HDR; else state_d = IDLE;
      HDR:     if (!stall) state_d = is_rd_q ? IDLE : DATA; else state_d = HDR;
      DATA:    if (tail_xfer_s) state_d = IDLE; else state_d = DATA;
      default: state_d = IDLE;
    endcase
    if (accept_s && !dec_s) begin
      outst_d = outst_q + 4'd1;
    end else if (dec_s && !accept_s) begin
      outst_d = outst_q - 4'd1;
    end else begin
      outst_d = outst_q;
    end
    if (accept_s) prio_rd_d = !prio_rd_q; else prio_rd_d = prio_rd_q;
  end

  // Capture the granted request fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_rd_q <= 1'b0; id_q <= 4'd0; addr_q <= 32'd0; len_q <= 4'd0; size_q <= 3'd0;
      burst_q <= 2'd0; lock_q <= 1'b0; cache_q <= 4'd0; prot_q <= 3'd0;
    end else if (accept_s) begin
      is_rd_q <= grant_rd_s;
      id_q    <= grant_rd_s ? 4'(ARID)    : 4'(AWID);
      addr_q  <= grant_rd_s ? ARADDR      : AWADDR;
      len_q   <= grant_rd_s ? ARLEN       : AWLEN;
      size_q  <= grant_rd_s ? ARSIZE      : AWSIZE;
      burst_q <= grant_rd_s ? ARBURST     : AWBURST;
      lock_q  <= grant_rd_s ? ARLOCK[0]   : AWLOCK[0];
      cache_q <= grant_rd_s ? ARCACHE     : AWCACHE;
      prot_q  <= grant_rd_s ? ARPROT      : AWPROT;
    end
  end

  // Beat counter and single-entry payload flit buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q   <= 4'd0;
      beats_done_q <= 1'b0;
      data_flit_q  <= 80'd0;
      data_valid_q <= 1'b0;
    end else if (accept_s && grant_wr_s) begin
      beat_cnt_q   <= AWLEN;
      beats_done_q <= 1'b0;
    end else if (w_beat_s) begin
      if (beat_cnt_q != 4'd0) beat_cnt_q <= beat_cnt_q - 4'd1;
      beats_done_q <= (beat_cnt_q == 4'd0);
      data_flit_q  <= {((beat_cnt_q == 4'd0) ? 2'b10 : 2'b00), WSTRB, WDATA, 6'd0};
      data_valid_q <= 1'b1;
    end else if (data_xfer_s) begin
      data_valid_q <= 1'b0;
    end
  end

`ifdef NI_WLAST_CHECK_EN
  logic wlast_err_q;

  // Sticky flag: WLAST disagreed with the beat counter on some beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      wlast_err_q <= 1'b0;
    end else if (w_beat_s && (WLAST != (beat_cnt_q == 4'd0))) begin
      wlast_err_q <= 1'b1;
    end
  end

  assign wlast_err = wlast_err_q;
  assign unused_s  = ^{AWLOCK[1], ARLOCK[1]};
`else
  assign wlast_err = 1'b0;
  assign unused_s  = ^{AWLOCK[1], ARLOCK[1], WLAST};
`endif

endmodule

// File: tb/tb_axi_ni_request_packetizer.sv
// Randomized bench: AXI masters feed the packetizer, a transaction-level model predicts grants and the flit stream.
module tb_axi_ni_request_packetizer;

  localparam int OMAX = 2;
  localparam int IDW  = 4;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
    bit          bad;
  } wbeat_t;

  logic clk = 1'b0;
  logic rst;
  logic [IDW-1:0] AWID, ARID;
  logic [31:0] AWADDR, ARADDR;
  logic [3:0]  AWLEN, ARLEN, AWCACHE, ARCACHE;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0]  AWBURST, ARBURST, AWLOCK, ARLOCK;
  logic        AWVALID, AWREADY, ARVALID, ARREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [79:0] flit;
  logic        valid, stall;
  logic [3:0]  SOURCE, lut_address;
  logic [6:0]  lut_path;
  logic        resp_done, wlast_err;

  int n_vec = 0;
  int n_err = 0;

  logic [79:0] exp_q[$];
  wbeat_t      wq[$];
  logic [63:0] cur_wd[16];
  logic [7:0]  cur_ws[16];
  int          out_cnt;
  bit          prio_rd, err_m, first_rd;
  bit          ar_hs, aw_hs, w_hs;
  bit          prev_hold, acc_last;
  logic [79:0] prev_flit;
  int          stall_left, stuck;
  bit          mid_reset;

  always #5 clk = ~clk;

  function automatic logic [6:0] lut_fn(input logic [3:0] a);
    logic [6:0] t;
    t = {3'd0, a};
    return t * 7'd14;
  endfunction

  assign lut_path = lut_fn(lut_address);

  axi_ni_request_packetizer #(.OUTSTANDING_MAX(OMAX), .ID_WD(IDW)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .flit(flit), .valid(valid), .stall(stall), .SOURCE(SOURCE), .lut_address(lut_address),
    .lut_path(lut_path), .resp_done(resp_done), .wlast_err(wlast_err)
  );

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [79:0] hdr(input bit rd, input logic [3:0] id, input logic [31:0] a,
                                      input logic [3:0] len, input logic [2:0] sz, input logic [1:0] bu,
                                      input logic lk, input logic [3:0] ca, input logic [2:0] pr);
    return {(rd ? 2'b11 : 2'b01), lut_fn(a[31:28]), SOURCE, rd, id, a, len, sz, bu, lk, ca, pr, 13'd0};
  endfunction

  task automatic gen_read();
    if (first_rd) begin
      ARADDR = 32'h3000_0010; ARID = 4'd5; ARLEN = 4'd0; first_rd = 1'b0;
    end else begin
      ARADDR = $urandom; ARID = 4'($urandom); ARLEN = 4'($urandom);
    end
    ARSIZE = 3'($urandom); ARBURST = 2'($urandom); ARLOCK = 2'($urandom);
    ARCACHE = 4'($urandom); ARPROT = 3'($urandom);
    ARVALID = 1'b1;
  endtask

  task automatic gen_write();
    wbeat_t b;
    AWADDR = $urandom; AWID = 4'($urandom);
    AWLEN = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
    AWSIZE = 3'($urandom); AWBURST = 2'($urandom); AWLOCK = 2'($urandom);
    AWCACHE = 4'($urandom); AWPROT = 3'($urandom);
    for (int i = 0; i <= int'(AWLEN); i++) begin
      b.d = {$urandom, $urandom};
      b.s = 8'($urandom);
      b.l = (i == int'(AWLEN));
      b.bad = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        b.l = ~b.l;
        b.bad = 1'b1;
      end
      cur_wd[i] = b.d;
      cur_ws[i] = b.s;
      wq.push_back(b);
    end
    AWVALID = 1'b1;
  endtask

  initial begin
    bit idle, can, exp_ar, exp_aw;
    rst = 1'b1; SOURCE = 4'd8; stall = 1'b0; resp_done = 1'b0;
    AWVALID = 1'b0; ARVALID = 1'b0; WVALID = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWLOCK = '0; AWCACHE = '0; AWPROT = '0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARLOCK = '0; ARCACHE = '0; ARPROT = '0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0;
    out_cnt = 0; prio_rd = 1'b1; err_m = 1'b0; first_rd = 1'b1;
    ar_hs = 1'b0; aw_hs = 1'b0; w_hs = 1'b0; prev_hold = 1'b0; acc_last = 1'b0;
    prev_flit = '0; stall_left = 0; stuck = 0; mid_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", 80'(valid), 80'd0);
    chk("rst_flit", flit, 80'd0);
    chk("rst_ready", 80'({AWREADY, ARREADY, WREADY}), 80'd0);
    chk("rst_wlast_err", 80'(wlast_err), 80'd0);

    for (int cyc = 0; cyc < 6000 && !mid_reset; cyc++) begin
      @(posedge clk);
      #1;
      if (ar_hs) ARVALID = 1'b0;
      if (aw_hs) AWVALID = 1'b0;
      if (w_hs) void'(wq.pop_front());
      if (!ARVALID && $urandom_range(0, 2) == 0) gen_read();
      if (!AWVALID && $urandom_range(0, 2) == 0) gen_write();
      if (wq.size() > 0) begin
        if (!WVALID) WVALID = ($urandom_range(0, 3) != 0);
        WDATA = wq[0].d; WSTRB = wq[0].s; WLAST = wq[0].l;
      end else begin
        WVALID = 1'b0;
      end
      if (stall_left > 0) begin
        stall = 1'b1; stall_left--;
      end else if ($urandom_range(0, 30) == 0) begin
        stall = 1'b1; stall_left = 4;
      end else begin
        stall = ($urandom_range(0, 3) == 0);
      end
      resp_done = ($urandom_range(0, 5) == 0);
      #1;

      idle   = (exp_q.size() == 0);
      can    = idle && (out_cnt < OMAX);
      exp_ar = can && ARVALID && (!AWVALID || prio_rd);
      exp_aw = can && AWVALID && !(ARVALID && prio_rd);
      chk("arready", 80'(ARREADY), 80'(exp_ar));
      chk("awready", 80'(AWREADY), 80'(exp_aw));
      chk("wlast_err", 80'(wlast_err), 80'(err_m));
      if (acc_last) chk("hdr_latency", 80'(valid), 80'd1);
      if (prev_hold) begin
        chk("stall_valid", 80'(valid), 80'd1);
        chk("stall_flit", flit, prev_flit);
      end
      if (!idle && exp_q[0][78]) chk("lut_address", 80'(lut_address), 80'(exp_q[0][61:58]));
      if (idle || exp_q[0][78] || (valid && stall)) chk("wready_blocked", 80'(WREADY), 80'd0);

      if (valid && !stall) begin
        if (exp_q.size() == 0) chk("spurious_flit", 80'(valid), 80'd0);
        else chk("flit", flit, exp_q.pop_front());
        stuck = 0;
      end else if (!idle) begin
        stuck++;
      end else begin
        stuck = 0;
      end
      if (stuck > 400) begin
        chk("timeout", 80'(exp_q.size()), 80'd0);
        break;
      end

      if (exp_ar) exp_q.push_back(hdr(1'b1, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK[0], ARCACHE, ARPROT));
      if (exp_aw) begin
        exp_q.push_back(hdr(1'b0, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK[0], AWCACHE, AWPROT));
        for (int i = 0; i <= int'(AWLEN); i++)
          exp_q.push_back({((i == int'(AWLEN)) ? 2'b10 : 2'b00), cur_ws[i], cur_wd[i], 6'd0});
      end
`ifdef NI_WLAST_CHECK_EN
      if (WVALID && WREADY && wq.size() > 0 && wq[0].bad) err_m = 1'b1;
`endif
      if (resp_done && out_cnt > 0) out_cnt--;
      if (exp_ar || exp_aw) begin
        out_cnt++;
        prio_rd = !prio_rd;
      end
      ar_hs = ARVALID && ARREADY;
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      acc_last  = exp_ar || exp_aw;
      prev_hold = valid && stall;
      prev_flit = flit;
      if (cyc > 4000 && exp_q.size() > 1 && !exp_q[0][78] && !ar_hs && !aw_hs) mid_reset = 1'b1;
    end

    // Abort a write mid-packet and confirm nothing more of it appears.
    @(posedge clk);
    #1;
    rst = 1'b1; AWVALID = 1'b0; ARVALID = 1'b0; stall = 1'b0; resp_done = 1'b0;
    WVALID = 1'b1; WDATA = 64'hDEAD_BEEF_0123_4567; WSTRB = 8'hFF; WLAST = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("abort_valid", 80'(valid), 80'd0);
      chk("abort_flit", flit, 80'd0);
      chk("abort_wready", 80'(WREADY), 80'd0);
      chk("abort_wlast_err", 80'(wlast_err), 80'd0);
      @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
